// File: rtl/tensor_core_pkg.sv
// Shared types and helpers for the tensor-core operand path.
package tensor_core_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Register address of element 'offset' past 'base', wrapping at 2**aw.
  function automatic logic [31:0] wrap_address(input logic [31:0] base,
                                               input logic [31:0] offset,
                                               input int aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return (base + offset) & mask;
  endfunction

endpackage

// File: rtl/operand_output_stage.sv
// Single-entry valid/ready register carrying one {a, b, index, last} pair.
module operand_output_stage
  import tensor_core_pkg::*;
#(
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   load,
  input  logic                   ready,
  input  logic [DATA_WIDTH-1:0]  next_a,
  input  logic [DATA_WIDTH-1:0]  next_b,
  input  logic [INDEX_WIDTH-1:0] next_index,
  input  logic                   next_last,
  output logic                   valid,
  output logic [DATA_WIDTH-1:0]  a,
  output logic [DATA_WIDTH-1:0]  b,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   last
);

  // Load replaces the entry; a handshake with nothing new behind it empties it.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      valid <= 1'b0;
      a     <= '0;
      b     <= '0;
      index <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      a     <= next_a;
      b     <= next_b;
      index <= next_index;
      last  <= next_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/matrix_operand_fetcher.sv
// Walks two row-major operand matrices out of the register file and streams
// element pairs to the tensor-core datapath over valid/ready.
module matrix_operand_fetcher
  import tensor_core_pkg::*;
#(
  parameter  int NUMBER_OF_REGISTERS = 256,
  parameter  int MATRIX_DIM          = 4,
  localparam int AW                  = $clog2(NUMBER_OF_REGISTERS),
  localparam int ELEMENTS            = MATRIX_DIM * MATRIX_DIM,
  localparam int IW                  = $clog2(ELEMENTS)
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic [AW-1:0]         base_a_address_in,
  input  logic [AW-1:0]         base_b_address_in,
  output logic [AW-1:0]         read_register_address1_out,
  output logic [AW-1:0]         read_register_address2_out,
  input  logic [DATA_WIDTH-1:0] read_data1_in,
  input  logic [DATA_WIDTH-1:0] read_data2_in,
  output logic                  operand_valid_out,
  input  logic                  operand_ready_in,
  output logic [DATA_WIDTH-1:0] operand_a_out,
  output logic [DATA_WIDTH-1:0] operand_b_out,
  output logic [IW-1:0]         operand_index_out,
  output logic                  last_out,
  output logic                  busy_out,
  output logic                  done_out
);

  fetch_state_t  state;
  logic [AW-1:0] base_a;
  logic [AW-1:0] base_b;
  logic [IW-1:0] fetch_index;
  logic          load;
  logic          handshake;
  logic          fetch_last;

  // Capture whenever fetching and the output slot is empty or being drained.
  assign load       = (state == FETCH) && (!operand_valid_out || operand_ready_in);
  assign handshake  = operand_valid_out && operand_ready_in;
  assign fetch_last = (fetch_index == IW'(ELEMENTS - 1));
  assign busy_out   = (state != IDLE);

  // Read ports are parked at 0 whenever no fetch is in flight.
  assign read_register_address1_out = (state == FETCH) ?
    AW'(wrap_address(32'(base_a), 32'(fetch_index), AW)) : '0;
  assign read_register_address2_out = (state == FETCH) ?
    AW'(wrap_address(32'(base_b), 32'(fetch_index), AW)) : '0;

  // Sequencer: start latches bases, FETCH walks the index, DRAIN waits for the last pair.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state       <= IDLE;
      base_a      <= '0;
      base_b      <= '0;
      fetch_index <= '0;
      done_out    <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            base_a      <= base_a_address_in;
            base_b      <= base_b_address_in;
            fetch_index <= '0;
            state       <= FETCH;
          end
        end
        FETCH: begin
          if (load) begin
            fetch_index <= fetch_index + IW'(1);
            if (fetch_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Only the final pair can be resident here; its handshake ends the job.
          if (handshake && last_out) begin
            state    <= IDLE;
            done_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  operand_output_stage #(
    .INDEX_WIDTH(IW)
  ) u_output_stage (
    .clock_in   (clock_in),
    .reset_in   (reset_in),
    .load       (load),
    .ready      (operand_ready_in),
    .next_a     (read_data1_in),
    .next_b     (read_data2_in),
    .next_index (fetch_index),
    .next_last  (fetch_last),
    .valid      (operand_valid_out),
    .a          (operand_a_out),
    .b          (operand_b_out),
    .index      (operand_index_out),
    .last       (last_out)
  );

endmodule

// File: tb/tb_matrix_operand_fetcher.sv
// Self-checking bench for matrix_operand_fetcher with a behavioural register file.
module tb_matrix_operand_fetcher;

  localparam int NR = 256;
  localparam int EL = 16;

  logic       clock_in = 1'b0;
  logic       reset_in = 1'b1;
  logic       start_in = 1'b0;
  logic [7:0] base_a_in = '0, base_b_in = '0;
  logic [7:0] addr1, addr2, rd1, rd2, op_a, op_b;
  logic       valid, ready = 1'b0, last, busy, done;
  logic [3:0] idx;

  logic [7:0] mem [NR];
  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = '0, wr_data = '0;

  int checks = 0, errors = 0, cyc = 0;

  // Observation record of one job
  logic [7:0] oa[$], ob[$];
  int         oi[$], hs[$], addr_log[$];
  bit         ol[$];
  int         t_start, first_valid, done_cyc, busy_cnt, hold_viol;
  logic [7:0] exp_a[EL], exp_b[EL];

  always #5 clock_in = ~clock_in;
  always @(posedge clock_in) cyc <= cyc + 1;
  always @(posedge clock_in) if (wr_en) mem[wr_addr] <= wr_data;
  assign rd1 = mem[addr1];
  assign rd2 = mem[addr2];

  matrix_operand_fetcher dut (
    .clock_in(clock_in), .reset_in(reset_in), .start_in(start_in),
    .base_a_address_in(base_a_in), .base_b_address_in(base_b_in),
    .read_register_address1_out(addr1), .read_register_address2_out(addr2),
    .read_data1_in(rd1), .read_data2_in(rd2),
    .operand_valid_out(valid), .operand_ready_in(ready),
    .operand_a_out(op_a), .operand_b_out(op_b), .operand_index_out(idx),
    .last_out(last), .busy_out(busy), .done_out(done)
  );

  task automatic rf_write(input int a, input logic [7:0] d);
    @(negedge clock_in);
    wr_en = 1'b1; wr_addr = 8'(a); wr_data = d;
    @(negedge clock_in);
    wr_en = 1'b0;
  endtask

  task automatic preload_basic();
    for (int k = 0; k < EL; k++) rf_write(k, 8'(8'h10 + k));
    for (int k = 0; k < EL; k++) rf_write(32 + k, 8'(8'h40 + k));
  endtask

  // Reference: element k of each matrix is the register at (base + k) mod depth.
  task automatic snapshot(input logic [7:0] ba, input logic [7:0] bb);
    for (int k = 0; k < EL; k++) begin
      exp_a[k] = mem[(int'(ba) + k) % NR];
      exp_b[k] = mem[(int'(bb) + k) % NR];
    end
  endtask

  // Drives one job (optionally starting it) and records what the consumer sees.
  task automatic collect(input bit do_start, input logic [7:0] ba, input logic [7:0] bb,
                         input int stall_idx, input int stall_len, input bit rand_rdy,
                         input int busy_idx, input int wr_reg, input bit chain);
    int stall_left = 0;
    bit stalled = 0, pulsed = 0, wrote = 0;
    logic pv = 0, pr = 0, pl = 0;
    logic [7:0] pa = 0, pb = 0;
    logic [3:0] pi = 0;
    oa.delete(); ob.delete(); oi.delete(); ol.delete(); hs.delete(); addr_log.delete();
    first_valid = -1; done_cyc = -1; busy_cnt = 0; hold_viol = 0;
    if (do_start) begin
      @(negedge clock_in);
      base_a_in = ba; base_b_in = bb; start_in = 1'b1; t_start = cyc;
    end
    for (int n = 0; n < 300 && done_cyc < 0; n++) begin
      @(negedge clock_in);
      start_in = 1'b0; wr_en = 1'b0;
      if (pv && !pr && (!valid || op_a !== pa || op_b !== pb || idx !== pi || last !== pl))
        hold_viol++;
      addr_log.push_back(int'(addr1));
      busy_cnt += int'(busy);
      if (busy_idx >= 0 && !pulsed && valid && int'(idx) == busy_idx) begin
        start_in = 1'b1; base_a_in = ba + 8'd100; base_b_in = bb + 8'd100; pulsed = 1;
      end
      if (wr_reg >= 0 && !wrote && busy && int'(addr1) == wr_reg) begin
        wr_en = 1'b1; wr_addr = 8'(wr_reg); wr_data = 8'hAA; wrote = 1;
      end
      if (!stalled && valid && int'(idx) == stall_idx) begin
        stalled = 1; stall_left = stall_len;
      end
      if (stall_left > 0) begin ready = 1'b0; stall_left--; end
      else ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid && first_valid < 0) first_valid = cyc;
      if (valid && ready) begin
        oa.push_back(op_a); ob.push_back(op_b); oi.push_back(int'(idx));
        ol.push_back(last); hs.push_back(cyc);
      end
      if (done) begin
        done_cyc = cyc;
        if (chain) begin base_a_in = ba; base_b_in = bb; start_in = 1'b1; t_start = cyc; end
      end
      pv = valid; pr = ready; pa = op_a; pb = op_b; pi = idx; pl = last;
    end
    ready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock_in);
    checks++;
    if ({valid, op_a, op_b, idx, last, busy, done, addr1, addr2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b a=%h b=%h i=%0d l=%b busy=%b done=%b a1=%h a2=%h want all 0",
               valid, op_a, op_b, idx, last, busy, done, addr1, addr2);
    end
    for (int k = 0; k < NR; k++) rf_write(k, 8'($urandom));
    @(negedge clock_in);
    reset_in = 1'b0;
    ready = 1'b1;
    @(negedge clock_in);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy=%b valid=%b want 0 0", busy, valid);
    end
  endtask

  task automatic test_basic();
    preload_basic();
    snapshot(8'd0, 8'd32);
    collect(1, 8'd0, 8'd32, -1, 0, 0, -1, -1, 0);
    checks++;
    if (done_cyc < 0 || oa.size() != EL) begin
      errors++; $display("FAIL basic_count got %0d pairs done=%0d want %0d pairs", oa.size(), done_cyc, EL);
    end
    for (int k = 0; k < EL && k < oa.size(); k++) begin
      checks++;
      if (oa[k] !== 8'(8'h10 + k) || ob[k] !== 8'(8'h40 + k) || oi[k] != k ||
          ol[k] != (k == EL - 1) || hs[k] != t_start + 2 + k) begin
        errors++;
        $display("FAIL basic_pair k=%0d got a=%h b=%h i=%0d l=%b cyc=%0d want a=%h b=%h i=%0d l=%b cyc=%0d",
                 k, oa[k], ob[k], oi[k], ol[k], hs[k], 8'(8'h10 + k), 8'(8'h40 + k), k, k == EL - 1, t_start + 2 + k);
      end
    end
    checks++;
    if (first_valid != t_start + 2) begin
      errors++; $display("FAIL basic_first_valid got %0d want %0d", first_valid, t_start + 2);
    end
    checks++;
    if (done_cyc != t_start + 2 + EL) begin
      errors++; $display("FAIL basic_done got %0d want %0d", done_cyc, t_start + 2 + EL);
    end
    checks++;
    if (busy_cnt != EL + 1) begin
      errors++; $display("FAIL basic_busy_cycles got %0d want %0d", busy_cnt, EL + 1);
    end
  endtask

  task automatic test_backpressure();
    snapshot(8'd0, 8'd32);
    collect(1, 8'd0, 8'd32, 5, 3, 0, -1, -1, 0);
    checks++;
    if (oa.size() != EL || hold_viol != 0) begin
      errors++; $display("FAIL bp_count_hold got %0d pairs %0d hold faults want %0d pairs 0 faults", oa.size(), hold_viol, EL);
    end
    for (int k = 0; k < EL && k < oa.size(); k++) begin
      checks++;
      if (oa[k] !== exp_a[k] || ob[k] !== exp_b[k] || oi[k] != k ||
          hs[k] != t_start + 2 + k + (k >= 5 ? 3 : 0)) begin
        errors++;
        $display("FAIL bp_pair k=%0d got a=%h b=%h i=%0d cyc=%0d want a=%h b=%h i=%0d cyc=%0d",
                 k, oa[k], ob[k], oi[k], hs[k], exp_a[k], exp_b[k], k, t_start + 2 + k + (k >= 5 ? 3 : 0));
      end
    end
    checks++;
    if (done_cyc != t_start + 2 + EL + 3) begin
      errors++; $display("FAIL bp_done got %0d want %0d", done_cyc, t_start + 2 + EL + 3);
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 6; k++) rf_write(250 + k, 8'(1 + k));
    for (int k = 0; k < 10; k++) rf_write(k, 8'(7 + k));
    snapshot(8'd250, 8'd32);
    collect(1, 8'd250, 8'd32, -1, 0, 0, -1, -1, 0);
    checks++;
    if (oa.size() != EL || addr_log.size() < EL + 1) begin
      errors++; $display("FAIL wrap_count got %0d pairs want %0d", oa.size(), EL);
    end
    for (int k = 0; k < EL && k < oa.size() && k < addr_log.size(); k++) begin
      checks++;
      if (oa[k] !== 8'(k + 1) || ob[k] !== exp_b[k] || addr_log[k] != (250 + k) % NR) begin
        errors++;
        $display("FAIL wrap_pair k=%0d got a=%h b=%h addr=%0d want a=%h b=%h addr=%0d",
                 k, oa[k], ob[k], addr_log[k], 8'(k + 1), exp_b[k], (250 + k) % NR);
      end
    end
    checks++;
    if (addr_log.size() > EL && addr_log[EL] != 0) begin
      errors++; $display("FAIL wrap_drain_addr got %0d want 0", addr_log[EL]);
    end
  endtask

  task automatic test_start_while_busy();
    preload_basic();
    snapshot(8'd0, 8'd32);
    collect(1, 8'd0, 8'd32, -1, 0, 0, 7, -1, 1);
    checks++;
    if (oa.size() != EL || done_cyc != hs[EL - 1] + 1) begin
      errors++; $display("FAIL busy_start_count got %0d pairs done=%0d want %0d pairs", oa.size(), done_cyc, EL);
    end
    for (int k = 0; k < EL && k < oa.size(); k++) begin
      checks++;
      if (oa[k] !== exp_a[k] || ob[k] !== exp_b[k] || oi[k] != k) begin
        errors++; $display("FAIL busy_start_pair k=%0d got a=%h b=%h i=%0d want a=%h b=%h i=%0d",
                           k, oa[k], ob[k], oi[k], exp_a[k], exp_b[k], k);
      end
    end
    // Start issued in the done cycle is the next job.
    collect(0, 8'd0, 8'd32, -1, 0, 0, -1, -1, 0);
    checks++;
    if (first_valid != t_start + 2 || oa.size() != EL) begin
      errors++; $display("FAIL done_cycle_start got first_valid=%0d pairs=%0d want %0d %0d",
                         first_valid, oa.size(), t_start + 2, EL);
    end
    checks++;
    if (oa.size() > 0 && (oa[0] !== exp_a[0] || oi[0] != 0)) begin
      errors++; $display("FAIL done_cycle_start_data got a=%h i=%0d want a=%h i=0", oa[0], oi[0], exp_a[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    bit found = 0;
    snapshot(8'd0, 8'd32);
    @(negedge clock_in);
    base_a_in = 8'd0; base_b_in = 8'd32; start_in = 1'b1; ready = 1'b1;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clock_in);
      start_in = 1'b0;
      if (valid && idx == 4'd9) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reset_mid_reach got no index 9 want index 9"); end
    #2 reset_in = 1'b1;
    #1;
    checks++;
    if ({valid, op_a, op_b, idx, last, busy, done, addr1, addr2} !== '0) begin
      errors++;
      $display("FAIL reset_async got v=%b a=%h b=%h i=%0d l=%b busy=%b done=%b a1=%h a2=%h want all 0",
               valid, op_a, op_b, idx, last, busy, done, addr1, addr2);
    end
    @(negedge clock_in);
    reset_in = 1'b0;
    collect(1, 8'd0, 8'd32, -1, 0, 0, -1, -1, 0);
    checks++;
    if (oa.size() != EL) begin errors++; $display("FAIL reset_restart_count got %0d want %0d", oa.size(), EL); end
    for (int k = 0; k < EL && k < oa.size(); k++) begin
      checks++;
      if (oi[k] != k || oa[k] !== exp_a[k] || ob[k] !== exp_b[k]) begin
        errors++; $display("FAIL reset_restart_pair k=%0d got i=%0d a=%h b=%h want i=%0d a=%h b=%h",
                           k, oi[k], oa[k], ob[k], k, exp_a[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_same_cycle_write();
    preload_basic();
    collect(1, 8'd0, 8'd32, -1, 0, 0, -1, 3, 0);
    checks++;
    if (oa.size() != EL || oa[3] !== 8'h13) begin
      errors++; $display("FAIL write_old_value got pairs=%0d a3=%h want %0d 13", oa.size(), oa[3], EL);
    end
    collect(1, 8'd0, 8'd32, -1, 0, 0, -1, -1, 0);
    checks++;
    if (oa.size() != EL || oa[3] !== 8'hAA) begin
      errors++; $display("FAIL write_new_value got pairs=%0d a3=%h want %0d aa", oa.size(), oa[3], EL);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      logic [7:0] ba = 8'($urandom), bb = 8'($urandom);
      for (int k = 0; k < EL; k++) rf_write((int'(ba) + k) % NR, 8'($urandom));
      for (int k = 0; k < EL; k++) rf_write((int'(bb) + k) % NR, 8'($urandom));
      snapshot(ba, bb);
      collect(1, ba, bb, -1, 0, 1, -1, -1, 0);
      checks++;
      if (oa.size() != EL || hold_viol != 0 || done_cyc != hs[hs.size() - 1] + 1) begin
        errors++; $display("FAIL rand_job r=%0d got pairs=%0d holdfaults=%0d done=%0d want %0d 0 last_hs+1",
                           r, oa.size(), hold_viol, done_cyc, EL);
      end
      for (int k = 0; k < EL && k < oa.size(); k++) begin
        checks++;
        if (oa[k] !== exp_a[k] || ob[k] !== exp_b[k] || oi[k] != k || ol[k] != (k == EL - 1)) begin
          errors++; $display("FAIL rand_pair r=%0d k=%0d got a=%h b=%h i=%0d l=%b want a=%h b=%h i=%0d l=%b",
                             r, k, oa[k], ob[k], oi[k], ol[k], exp_a[k], exp_b[k], k, k == EL - 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_start_while_busy();
    test_reset_mid_run();
    test_same_cycle_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
